r88_int_sequencer: RTL and testbench

R88_INT_SEQUENCER -- requirements
Module: r88_int_sequencer

---
 rtl/r88_pkg.sv | 34 +++
 rtl/r88_prio_enc.sv | 27 ++
 rtl/r88_int_sequencer.sv | 174 +++++++++++++++++
 tb/tb_r88_int_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/r88_pkg.sv
`default_nettype none
// ============================================================================
// Module      : r88_pkg
// Description : Shared encodings and vector-table constants for the r88
//               interrupt sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package r88_pkg;

  typedef enum logic [1:0] {
    KIND_RESET = 2'b00,
    KIND_NMI   = 2'b01,
    KIND_IRQ   = 2'b10,
    KIND_RSVD  = 2'b11
  } svc_kind_e;

  typedef enum logic [1:0] {
    RESET_SEQ = 2'd0,
    IDLE      = 2'd1,
    REQ       = 2'd2
  } seq_state_e;

  localparam logic [15:0] DEFAULT_VECTOR_BASE = 16'hFFE0;
  localparam logic [15:0] NMI_VEC_OFS         = 16'd2;
  localparam logic [15:0] IRQ_VEC_OFS         = 16'd4;

  // Two-byte vector slots; the sum wraps naturally at 16 bits.
  function automatic logic [15:0] irq_vector(input logic [15:0] base,
                                             input logic [15:0] chan);
    return base + IRQ_VEC_OFS + (chan << 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/r88_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : r88_prio_enc
// Description : Lowest-index-wins priority encoder with a valid flag.
// Revision    : 1.0  initial release
// ============================================================================
module r88_prio_enc
  import r88_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    valid = |req;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) index = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/r88_int_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : r88_int_sequencer
// Description : Reset/NMI/IRQ service sequencer with nested in-service
//               tracking and registered request outputs.
// Revision    : 1.0  initial release
// ============================================================================
module r88_int_sequencer
  import r88_pkg::*;
#(
  parameter int          IRQ_CHANNELS = 4,
  parameter logic [15:0] VECTOR_BASE  = DEFAULT_VECTOR_BASE,
  localparam int CHAN_W = (IRQ_CHANNELS > 1) ? $clog2(IRQ_CHANNELS) : 1
) (
  input  logic                    sysClock,
  input  logic                    resetReq,
  input  logic                    nmiReq,
  input  logic [IRQ_CHANNELS-1:0] irq,
  input  logic [IRQ_CHANNELS-1:0] irqMask,
  input  logic                    irqEn,
  input  logic                    instrBoundary,
  input  logic                    svcAck,
  input  logic                    retiDone,
  output logic                    svcReq,
  output logic [1:0]              svcKind,
  output logic [CHAN_W-1:0]       svcChan,
  output logic [15:0]             vecAddr,
  output logic                    nmiActive,
  output logic [IRQ_CHANNELS-1:0] irqActive
);

  seq_state_e              state_q, state_d;
  logic                    svc_req_q, svc_req_d;
  svc_kind_e               svc_kind_q, svc_kind_d;
  logic [CHAN_W-1:0]       svc_chan_q, svc_chan_d;
  logic [15:0]             vec_addr_q, vec_addr_d;
  logic                    nmi_active_q, nmi_active_d;
  logic [IRQ_CHANNELS-1:0] irq_active_q, irq_active_d;
  logic                    nmi_pend_q, nmi_pend_d;
  logic                    nmi_prev_q, nmi_prev_d;

  logic                    nmi_edge;
  logic                    nmi_eligible;
  logic                    ack;
  logic [IRQ_CHANNELS-1:0] below_active;
  logic [IRQ_CHANNELS-1:0] irq_elig;
  logic                    irq_valid;
  logic [CHAN_W-1:0]       irq_idx;
  logic [IRQ_CHANNELS-1:0] irq_lowest_active;
  logic [IRQ_CHANNELS-1:0] irq_clr;

  // An edge arriving this cycle already counts, so it can win at a boundary.
  assign nmi_edge     = nmiReq & ~nmi_prev_q;
  assign nmi_eligible = (nmi_pend_q | nmi_edge) & ~nmi_active_q;
  assign ack          = svcAck & svc_req_q;

  // Only channels strictly below the lowest in-service one may nest.
  always_comb begin
    logic seen;
    seen         = 1'b0;
    below_active = '0;
    for (int n = 0; n < IRQ_CHANNELS; n++) begin
      seen            = seen | irq_active_q[n];
      below_active[n] = ~seen;
    end
  end

  assign irq_elig = irq & irqMask & below_active
                  & {IRQ_CHANNELS{irqEn & ~nmi_active_q}};

  r88_prio_enc #(
    .WIDTH (IRQ_CHANNELS)
  ) u_prio_enc (
    .req   (irq_elig),
    .valid (irq_valid),
    .index (irq_idx)
  );

  assign irq_lowest_active = irq_active_q & (~irq_active_q + IRQ_CHANNELS'(1));
  assign irq_clr = (retiDone & ~nmi_active_q) ? irq_lowest_active : '0;

  always_comb begin
    state_d      = state_q;
    svc_req_d    = svc_req_q;
    svc_kind_d   = svc_kind_q;
    svc_chan_d   = svc_chan_q;
    vec_addr_d   = vec_addr_q;
    nmi_active_d = nmi_active_q & ~retiDone;
    irq_active_d = irq_active_q & ~irq_clr;
    nmi_pend_d   = nmi_pend_q;
    nmi_prev_d   = nmiReq;

    case (state_q)
      RESET_SEQ: begin
        svc_req_d  = 1'b1;
        svc_kind_d = KIND_RESET;
        svc_chan_d = '0;
        vec_addr_d = VECTOR_BASE;
        if (ack) begin
          state_d   = IDLE;
          svc_req_d = 1'b0;
        end
      end
      IDLE: begin
        svc_req_d = 1'b0;
        if (instrBoundary && (nmi_eligible || irq_valid)) begin
          state_d   = REQ;
          svc_req_d = 1'b1;
          if (nmi_eligible) begin
            svc_kind_d = KIND_NMI;
            svc_chan_d = '0;
            vec_addr_d = VECTOR_BASE + NMI_VEC_OFS;
          end else begin
            svc_kind_d = KIND_IRQ;
            svc_chan_d = irq_idx;
            vec_addr_d = irq_vector(VECTOR_BASE, 16'(irq_idx));
          end
        end
      end
      REQ: begin
        if (ack) begin
          state_d   = IDLE;
          svc_req_d = 1'b0;
          if (svc_kind_q == KIND_NMI) begin
            nmi_active_d = 1'b1;
            nmi_pend_d   = 1'b0;
          end else if (svc_kind_q == KIND_IRQ) begin
            irq_active_d[svc_chan_q] = 1'b1;
          end
        end
      end
      default: begin
        state_d   = RESET_SEQ;
        svc_req_d = 1'b0;
      end
    endcase

    // A fresh edge beats a same-cycle acknowledge clear.
    if (nmi_edge) nmi_pend_d = 1'b1;
  end

  always_ff @(posedge sysClock) begin
    if (resetReq) begin
      state_q      <= RESET_SEQ;
      svc_req_q    <= 1'b0;
      svc_kind_q   <= KIND_RESET;
      svc_chan_q   <= '0;
      vec_addr_q   <= VECTOR_BASE;
      nmi_active_q <= 1'b0;
      irq_active_q <= '0;
      nmi_pend_q   <= 1'b0;
      nmi_prev_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      svc_req_q    <= svc_req_d;
      svc_kind_q   <= svc_kind_d;
      svc_chan_q   <= svc_chan_d;
      vec_addr_q   <= vec_addr_d;
      nmi_active_q <= nmi_active_d;
      irq_active_q <= irq_active_d;
      nmi_pend_q   <= nmi_pend_d;
      nmi_prev_q   <= nmi_prev_d;
    end
  end

  assign svcReq    = svc_req_q;
  assign svcKind   = svc_kind_q;
  assign svcChan   = svc_chan_q;
  assign vecAddr   = vec_addr_q;
  assign nmiActive = nmi_active_q;
  assign irqActive = irq_active_q;

endmodule
`default_nettype wire

// File: tb/tb_r88_int_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_r88_int_sequencer
// Description : Directed vector bench for r88_int_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_r88_int_sequencer;

  logic       sysClock      = 1'b0;
  logic       resetReq      = 1'b1;
  logic       nmiReq        = 1'b0;
  logic [3:0] irq           = 4'b0000;
  logic [3:0] irqMask       = 4'hF;
  logic       irqEn         = 1'b1;
  logic       instrBoundary = 1'b0;
  logic       svcAck        = 1'b0;
  logic       retiDone      = 1'b0;
  logic       svcReq;
  logic [1:0] svcKind;
  logic [1:0] svcChan;
  logic [15:0] vecAddr;
  logic       nmiActive;
  logic [3:0] irqActive;

  r88_int_sequencer #(
    .IRQ_CHANNELS (4),
    .VECTOR_BASE  (16'hFFE0)
  ) dut (
    .sysClock      (sysClock),
    .resetReq      (resetReq),
    .nmiReq        (nmiReq),
    .irq           (irq),
    .irqMask       (irqMask),
    .irqEn         (irqEn),
    .instrBoundary (instrBoundary),
    .svcAck        (svcAck),
    .retiDone      (retiDone),
    .svcReq        (svcReq),
    .svcKind       (svcKind),
    .svcChan       (svcChan),
    .vecAddr       (vecAddr),
    .nmiActive     (nmiActive),
    .irqActive     (irqActive)
  );

  always #5 sysClock = ~sysClock;

  typedef struct {
    string       nm;
    logic        rst;
    logic        nmi;
    logic [3:0]  irq;
    logic        ib;
    logic        ack;
    logic        reti;
    logic        req;
    logic [1:0]  kind;
    logic [1:0]  chan;
    logic [15:0] vec;
    logic        nact;
    logic [3:0]  iact;
  } vec_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic rst, logic nmi, logic [3:0] irq_i,
                              logic ib, logic ack, logic reti, logic req,
                              logic [1:0] kind, logic [1:0] chan, logic [15:0] vec,
                              logic nact, logic [3:0] iact);
    vec_t t;
    t.nm = nm; t.rst = rst; t.nmi = nmi; t.irq = irq_i; t.ib = ib; t.ack = ack;
    t.reti = reti; t.req = req; t.kind = kind; t.chan = chan; t.vec = vec;
    t.nact = nact; t.iact = iact;
    return t;
  endfunction

  // Drive one cycle of inputs, then check the registered outputs just after the edge.
  task automatic run(input vec_t t);
    resetReq = t.rst; nmiReq = t.nmi; irq = t.irq;
    instrBoundary = t.ib; svcAck = t.ack; retiDone = t.reti;
    @(posedge sysClock);
    #1;
    n_chk++;
    if ({svcReq, svcKind, svcChan, vecAddr, nmiActive, irqActive} !==
        {t.req, t.kind, t.chan, t.vec, t.nact, t.iact}) begin
      n_fail++;
      $display("FAIL %s: got req=%0d kind=%b chan=%0d vec=%h nact=%0d iact=%b, expected req=%0d kind=%b chan=%0d vec=%h nact=%0d iact=%b",
               t.nm, svcReq, svcKind, svcChan, vecAddr, nmiActive, irqActive,
               t.req, t.kind, t.chan, t.vec, t.nact, t.iact);
    end
  endtask

  initial begin
    //             name          rst nmi irq     ib ack reti req kind   ch vec        na iact
    tbl.push_back(mk("reset",      1, 0, 4'b0000, 0, 0, 0,  0, 2'b00, 0, 16'hFFE0, 0, 4'b0000));
    tbl.push_back(mk("rst_seq",    0, 0, 4'b0000, 0, 0, 0,  1, 2'b00, 0, 16'hFFE0, 0, 4'b0000));
    tbl.push_back(mk("rst_ack",    0, 0, 4'b0000, 0, 1, 0,  0, 2'b00, 0, 16'hFFE0, 0, 4'b0000));
    tbl.push_back(mk("no_bound",   0, 0, 4'b1010, 0, 0, 0,  0, 2'b00, 0, 16'hFFE0, 0, 4'b0000));
    tbl.push_back(mk("irq1_req",   0, 0, 4'b1010, 1, 0, 0,  1, 2'b10, 1, 16'hFFE6, 0, 4'b0000));
    tbl.push_back(mk("irq1_ack",   0, 0, 4'b1010, 0, 1, 0,  0, 2'b10, 1, 16'hFFE6, 0, 4'b0010));
    tbl.push_back(mk("irq3_blk",   0, 0, 4'b1000, 1, 0, 0,  0, 2'b10, 1, 16'hFFE6, 0, 4'b0010));
    tbl.push_back(mk("irq0_pre",   0, 0, 4'b1001, 1, 0, 0,  1, 2'b10, 0, 16'hFFE4, 0, 4'b0010));
    tbl.push_back(mk("irq0_ack",   0, 0, 4'b1001, 0, 1, 0,  0, 2'b10, 0, 16'hFFE4, 0, 4'b0011));
    tbl.push_back(mk("reti_b0",    0, 0, 4'b0000, 0, 0, 1,  0, 2'b10, 0, 16'hFFE4, 0, 4'b0010));
    tbl.push_back(mk("reti_b1",    0, 0, 4'b0000, 0, 0, 1,  0, 2'b10, 0, 16'hFFE4, 0, 4'b0000));
    tbl.push_back(mk("reti_none",  0, 0, 4'b0000, 0, 0, 1,  0, 2'b10, 0, 16'hFFE4, 0, 4'b0000));
    tbl.push_back(mk("nmi_first",  0, 1, 4'b0001, 1, 0, 0,  1, 2'b01, 0, 16'hFFE2, 0, 4'b0000));
    tbl.push_back(mk("nmi_ack",    0, 1, 4'b0001, 0, 1, 0,  0, 2'b01, 0, 16'hFFE2, 1, 4'b0000));
    tbl.push_back(mk("nmi_blkirq", 0, 0, 4'b0001, 1, 0, 0,  0, 2'b01, 0, 16'hFFE2, 1, 4'b0000));
    tbl.push_back(mk("nmi2_edge",  0, 1, 4'b0001, 1, 0, 0,  0, 2'b01, 0, 16'hFFE2, 1, 4'b0000));
    tbl.push_back(mk("nmi2_wait",  0, 1, 4'b0001, 1, 0, 0,  0, 2'b01, 0, 16'hFFE2, 1, 4'b0000));
    tbl.push_back(mk("nmi_reti",   0, 1, 4'b0001, 0, 0, 1,  0, 2'b01, 0, 16'hFFE2, 0, 4'b0000));
    tbl.push_back(mk("nmi2_req",   0, 1, 4'b0001, 1, 0, 0,  1, 2'b01, 0, 16'hFFE2, 0, 4'b0000));
    tbl.push_back(mk("nmi2_ack",   0, 1, 4'b0001, 0, 1, 0,  0, 2'b01, 0, 16'hFFE2, 1, 4'b0000));
    tbl.push_back(mk("nmi2_reti",  0, 0, 4'b0000, 0, 0, 1,  0, 2'b01, 0, 16'hFFE2, 0, 4'b0000));
    tbl.push_back(mk("irq2_req",   0, 0, 4'b0100, 1, 0, 0,  1, 2'b10, 2, 16'hFFE8, 0, 4'b0000));
    tbl.push_back(mk("irq2_drop",  0, 0, 4'b0000, 0, 0, 0,  1, 2'b10, 2, 16'hFFE8, 0, 4'b0000));
    tbl.push_back(mk("irq2_nmi",   0, 1, 4'b0000, 1, 0, 0,  1, 2'b10, 2, 16'hFFE8, 0, 4'b0000));
    tbl.push_back(mk("irq2_ack",   0, 1, 4'b0000, 0, 1, 0,  0, 2'b10, 2, 16'hFFE8, 0, 4'b0100));
    tbl.push_back(mk("nmi3_req",   0, 1, 4'b0000, 1, 0, 0,  1, 2'b01, 0, 16'hFFE2, 0, 4'b0100));
    tbl.push_back(mk("nmi3_ack",   0, 1, 4'b0000, 0, 1, 0,  0, 2'b01, 0, 16'hFFE2, 1, 4'b0100));
    tbl.push_back(mk("reti_nmi1st",0, 1, 4'b0000, 0, 0, 1,  0, 2'b01, 0, 16'hFFE2, 0, 4'b0100));
    tbl.push_back(mk("reti_irq2",  0, 0, 4'b0000, 0, 0, 1,  0, 2'b01, 0, 16'hFFE2, 0, 4'b0000));
    tbl.push_back(mk("irq0_req",   0, 0, 4'b0001, 1, 0, 0,  1, 2'b10, 0, 16'hFFE4, 0, 4'b0000));
    tbl.push_back(mk("rst_midreq", 1, 0, 4'b0001, 0, 0, 0,  0, 2'b00, 0, 16'hFFE0, 0, 4'b0000));
    tbl.push_back(mk("rst_seq2",   0, 0, 4'b0001, 0, 0, 0,  1, 2'b00, 0, 16'hFFE0, 0, 4'b0000));
    tbl.push_back(mk("rst_ack2",   0, 0, 4'b0000, 0, 1, 0,  0, 2'b00, 0, 16'hFFE0, 0, 4'b0000));

    foreach (tbl[i]) run(tbl[i]);

    // Stray acknowledge and gating by irqEn / irqMask.
    run(mk("ack_noreq",  0, 0, 4'b0000, 0, 1, 0, 0, 2'b00, 0, 16'hFFE0, 0, 4'b0000));
    irqEn = 1'b0;
    run(mk("en_off",     0, 0, 4'b0001, 1, 0, 0, 0, 2'b00, 0, 16'hFFE0, 0, 4'b0000));
    irqEn = 1'b1; irqMask = 4'b1110;
    run(mk("mask_off",   0, 0, 4'b0001, 1, 0, 0, 0, 2'b00, 0, 16'hFFE0, 0, 4'b0000));
    irqMask = 4'hF;

    // NMI edge landing on the same cycle as its own acknowledge stays pending.
    run(mk("e_req",      0, 1, 4'b0000, 1, 0, 0, 1, 2'b01, 0, 16'hFFE2, 0, 4'b0000));
    run(mk("e_hold",     0, 0, 4'b0000, 0, 0, 0, 1, 2'b01, 0, 16'hFFE2, 0, 4'b0000));
    run(mk("e_ack_edge", 0, 1, 4'b0000, 0, 1, 0, 0, 2'b01, 0, 16'hFFE2, 1, 4'b0000));
    run(mk("e_reti",     0, 1, 4'b0000, 0, 0, 1, 0, 2'b01, 0, 16'hFFE2, 0, 4'b0000));
    run(mk("e_repend",   0, 1, 4'b0000, 1, 0, 0, 1, 2'b01, 0, 16'hFFE2, 0, 4'b0000));
    run(mk("e_ack2",     0, 1, 4'b0000, 0, 1, 0, 0, 2'b01, 0, 16'hFFE2, 1, 4'b0000));
    run(mk("e_reti2",    0, 0, 4'b0000, 0, 0, 1, 0, 2'b01, 0, 16'hFFE2, 0, 4'b0000));

    // retiDone coinciding with svcAck clears the pre-cycle lowest bit (2), sets bit 0.
    run(mk("c_irq2",     0, 0, 4'b0100, 1, 0, 0, 1, 2'b10, 2, 16'hFFE8, 0, 4'b0000));
    run(mk("c_ack2",     0, 0, 4'b0100, 0, 1, 0, 0, 2'b10, 2, 16'hFFE8, 0, 4'b0100));
    run(mk("c_irq0",     0, 0, 4'b0001, 1, 0, 0, 1, 2'b10, 0, 16'hFFE4, 0, 4'b0100));
    run(mk("c_ack_reti", 0, 0, 4'b0000, 0, 1, 1, 0, 2'b10, 0, 16'hFFE4, 0, 4'b0001));
    run(mk("c_reti",     0, 0, 4'b0000, 0, 0, 1, 0, 2'b10, 0, 16'hFFE4, 0, 4'b0000));

    // nmiReq held high through reset must not fire; early ack is ignored.
    run(mk("h_rst",      1, 1, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 16'hFFE0, 0, 4'b0000));
    run(mk("h_early_ack",0, 1, 4'b0000, 0, 1, 0, 1, 2'b00, 0, 16'hFFE0, 0, 4'b0000));
    run(mk("h_ack",      0, 1, 4'b0000, 0, 1, 0, 0, 2'b00, 0, 16'hFFE0, 0, 4'b0000));
    run(mk("h_no_nmi",   0, 1, 4'b0000, 1, 0, 0, 0, 2'b00, 0, 16'hFFE0, 0, 4'b0000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
